// File: rtl/frame_scanout_if.sv
// frame_scanout_if: valid/ready pixel stream with start-of-frame and end-of-line markers
interface frame_scanout_if #(parameter int DATA_W = 16);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  logic sof;
  logic eol;
  modport master(output valid, data, sof, eol, input ready);
  modport slave(input valid, data, sof, eol, output ready);
endinterface

// File: rtl/frame_scanout.sv
// frame_scanout: raster read-address generator and tear-free pixel streamer for a double frame buffer
module frame_scanout #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic continuous,
  input  logic swap_req,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic front_select,
  output logic busy,
  output logic frame_done,
  frame_scanout_if.master m
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic last;
    logic sof;
    logic eol;
    logic [DATA_W-1:0] data;
  } ent_t;
  state_t state, state_n;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic fly, fly_last, fly_sof, fly_eol;
  ent_t mem [2];
  ent_t head;
  logic wp, rp;
  logic [1:0] cnt;
  logic swap_pend;
  logic issue, pop, x_end, last_addr, final_xfer;
  assign head = mem[rp];
  assign m.valid = cnt != 2'd0;
  assign m.data = head.data;
  assign m.sof = m.valid && head.sof;
  assign m.eol = m.valid && head.eol;
  assign busy = state != IDLE;
  assign pop = m.valid && m.ready;
  assign x_end = x == XW'(H_PIXELS - 1);
  assign last_addr = x_end && y == YW'(V_LINES - 1);
  assign issue = state == RUN && (int'(cnt) + int'(fly) - int'(pop)) < 2;
  assign final_xfer = pop && head.last;
  always_comb begin
    state_n = (state == IDLE && start) ? RUN :
              (issue && last_addr) ? DRAIN :
              final_xfer ? (continuous ? RUN : IDLE) : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      read_addr <= '0;
      fly <= 1'b0;
      fly_last <= 1'b0;
      fly_sof <= 1'b0;
      fly_eol <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      swap_pend <= 1'b0;
      front_select <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      frame_done <= final_xfer;
      fly <= issue;
      fly_last <= last_addr;
      fly_sof <= read_addr == '0;
      fly_eol <= x_end;
      if (issue) begin
        x <= x_end ? '0 : x + 1'b1;
        y <= last_addr ? '0 : x_end ? y + 1'b1 : y;
        read_addr <= last_addr ? '0 : read_addr + 1'b1;
      end
      if (fly) begin
        mem[wp] <= {fly_last, fly_sof, fly_eol, read_data};
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, fly} - {1'b0, pop};
      if (final_xfer) begin
        front_select <= front_select ^ (swap_pend | swap_req);
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        if (state == IDLE) front_select <= ~front_select;
        else swap_pend <= 1'b1;
      end
    end
  end
endmodule
